tsn_dgcl_wr_arb: RTL and testbench
==================================

// Module: tsn_dgcl_wr_arb
// PURPOSE
//  Parametrised N-channel TSN-DMA write-path arbiter for the DGCL, single clock domain (gemmini_clk).
//  - Grants one DMA channel at a time, round-robin.
//  - Parses the header beat and forwards the payload beats to the Gemmini write-control command (wcc) port.
//  - Adds opcode checking, per-packet timeout abort and error reporting.
// PARAMETERS
//  NUM_CH      4       number of TSN-DMA channels (2..8)
//  DW          128     data beat width; must be >= 80
//  AW          40      DRAM address width (<= 40)
//  WR_OPCODE   8'h01   header opcode that marks a valid write packet
//  TIMEOUT     1024    idle cycles allowed between accepted beats inside a packet; 0 disables
// PORTS
//  gemmini_clk     in   1              clock
//  reset           in   1              asynchronous, active-high reset
//  dma_req         in   NUM_CH         per-channel request
//  dma_resp        out  NUM_CH         one-hot; granted channel owns the path
//  dma_write_valid in   NUM_CH         per-channel beat valid
//  dma_write_data  in   NUM_CH*DW      channel k occupies bits [k*DW +: DW]
//  dma_write_ready out  NUM_CH         per-channel beat ready
//  wcc_dram_addr   out  AW             header DRAM address, held for the whole packet
//  wcc_dpram_addr  out  16             header DPRAM address, held for the whole packet
//  wcc_length      out  16             header length in beats, held for the whole packet
//  wcc_write_data  out  DW             payload beat
//  wcc_valid       out  1              payload beat valid
//  wcc_ready       in   1              Gemmini accepts beat
//  grant_id        out  $clog2(NUM_CH) index of the current or last granted channel
//  busy            out  1              high in any state except IDLE
//  err_opcode      out  1              1-cycle pulse on opcode mismatch
//  err_zero_len    out  1              1-cycle pulse on length==0
//  err_timeout     out  1              1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; round-robin pointer rr=0; counters 0.
//  Header beat layout:
//    [AW-1:0]  dram addr
//    [55:40]   dpram addr
//    [71:56]   length L (beats)
//    [79:72]   opcode
//  IDLE:
//    - If any dma_req is set, pick the first requester scanning rr, rr+1, ... (mod NUM_CH).
//    - Register grant_id, go to HDR; dma_resp[g] rises on the next cycle.
//  HDR:
//    - dma_resp[g]=1, dma_write_ready[g]=1.
//    - On a beat accept, register addr/dpram/L and set cnt=0, then branch:
//      - L==0: pulse err_zero_len, go to REL.
//      - opcode!=WR_OPCODE: pulse err_opcode, go to DRAIN.
//      - otherwise go to DATA.
//  DATA:
//    - Combinational pass-through:
//      - wcc_valid = dma_write_valid[g]
//      - dma_write_ready[g] = wcc_ready
//      - wcc_write_data = channel g data
//    - On each accept, cnt++. Accept with cnt==L-1 -> REL.
//  DRAIN:
//    - dma_write_ready[g]=1, wcc_valid=0; L beats are consumed and discarded.
//    - Accept with cnt==L-1 -> REL.
//  REL (1 cycle):
//    - dma_resp=0, rr=g+1 mod NUM_CH, go to IDLE.
//    - Minimum 1 cycle gap between packets.
//  Outputs for non-granted channels: dma_resp and dma_write_ready are always 0.
//  Timeout:
//    - idle counter runs in HDR/DATA/DRAIN and clears on every accept.
//    - Reaching TIMEOUT: pulse err_timeout, drop the remainder (no beats forwarded), go to REL.
//    - In DATA, stall caused by wcc_ready=0 with valid=1 does NOT count.
//  Boundaries:
//    - Deasserting dma_req mid-packet is ignored; the packet runs to L beats.
//    - cnt is 16 bit, so L=65535 is legal.
//    - wcc_* header fields are stable from the HDR accept until REL.
//    - Reset mid-packet aborts immediately with no error pulse.
// TESTING
//  1. ch0 req, header L=3 op=01, 3 beats, wcc_ready=1 -> resp0 rises 1 cycle after req; 3 wcc beats in order; resp0 falls after 3rd.
//  2. ch1 and ch3 req together, rr=0 -> ch1 served first, then ch3. Repeat with ch1 still requesting -> ch3 is not starved.
//  3. Header op=8'h05, L=2 -> err_opcode pulse; 2 beats drained; wcc_valid stays 0; then REL.
//  4. Header L=0 -> err_zero_len pulse; no payload accepted; grant released 1 cycle later.
//  5. TIMEOUT=16, valid dropped after beat 1 of L=4 -> err_timeout 16 cycles later; resp0 falls; next requester granted.
//  6. wcc_ready=0 for 50 cycles with valid=1 (TIMEOUT=16) -> no timeout; data held; assert reset mid-packet -> all outputs 0.

Source files
------------

// File: rtl/tsn_dgcl_wr_arb.sv
// Round-robin write-path arbiter: grants one TSN-DMA channel at a time, parses its header
// beat and forwards the payload to the Gemmini write-control port, with opcode/length/timeout checks.
module tsn_dgcl_wr_arb #(
  parameter int         NUM_CH    = 4,
  parameter int         DW        = 128,
  parameter int         AW        = 40,
  parameter logic [7:0] WR_OPCODE = 8'h01,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                       gemmini_clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          dma_req,
  output logic [NUM_CH-1:0]          dma_resp,
  input  logic [NUM_CH-1:0]          dma_write_valid,
  input  logic [NUM_CH*DW-1:0]       dma_write_data,
  output logic [NUM_CH-1:0]          dma_write_ready,
  output logic [AW-1:0]              wcc_dram_addr,
  output logic [15:0]                wcc_dpram_addr,
  output logic [15:0]                wcc_length,
  output logic [DW-1:0]              wcc_write_data,
  output logic                       wcc_valid,
  input  logic                       wcc_ready,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy,
  output logic                       err_opcode,
  output logic                       err_zero_len,
  output logic                       err_timeout
);

  localparam int GW = $clog2(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN, S_REL} state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_grant, r_rr, w_pick;
  logic [15:0]     r_cnt, r_len;
  logic [AW-1:0]   r_dram_addr;
  logic [15:0]     r_dpram_addr;
  logic [31:0]     r_idle;
  logic            r_err_opcode, r_err_zero_len, r_err_timeout;

  logic            w_found, w_in_pkt, w_ch_valid, w_accept;
  logic            w_idle_tick, w_timeout_hit, w_last;
  logic [DW-1:0]   w_ch_data;
  logic [15:0]     w_hdr_len;
  logic [7:0]      w_hdr_op;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return GW'(s);
  endfunction

  assign w_in_pkt   = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_DRAIN);
  assign w_ch_valid = dma_write_valid[r_grant];
  assign w_ch_data  = dma_write_data[int'(r_grant)*DW +: DW];
  assign w_hdr_len  = w_ch_data[71:56];
  assign w_hdr_op   = w_ch_data[79:72];
  assign w_last     = (r_cnt == r_len - 16'd1);

  // Only a missing beat is idle time: a valid beat stalled by wcc_ready is Gemmini's backpressure.
  assign w_idle_tick   = w_in_pkt && !w_ch_valid;
  assign w_timeout_hit = (TIMEOUT != 0) && w_idle_tick && (r_idle == 32'(TIMEOUT - 1));

  always_comb begin
    w_pick  = r_rr;
    w_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && dma_req[rr_idx(r_rr, i)]) begin
        w_pick  = rr_idx(r_rr, i);
        w_found = 1'b1;
      end
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    dma_resp        = '0;
    dma_write_ready = '0;
    wcc_valid       = 1'b0;
    wcc_write_data  = '0;
    case (r_state)
      S_IDLE: if (w_found) w_next = S_HDR;
      S_HDR: begin
        dma_resp[r_grant]        = 1'b1;
        dma_write_ready[r_grant] = 1'b1;
        w_accept                 = w_ch_valid;
        if (w_accept) begin
          if (w_hdr_len == 16'd0)          w_next = S_REL;
          else if (w_hdr_op != WR_OPCODE)  w_next = S_DRAIN;
          else                             w_next = S_DATA;
        end else if (w_timeout_hit) begin
          w_next = S_REL;
        end
      end
      S_DATA: begin
        dma_resp[r_grant]        = 1'b1;
        dma_write_ready[r_grant] = wcc_ready;
        wcc_valid                = w_ch_valid;
        wcc_write_data           = w_ch_data;
        w_accept                 = w_ch_valid && wcc_ready;
        if ((w_accept && w_last) || w_timeout_hit) w_next = S_REL;
      end
      S_DRAIN: begin
        dma_resp[r_grant]        = 1'b1;
        dma_write_ready[r_grant] = 1'b1;
        w_accept                 = w_ch_valid;
        if ((w_accept && w_last) || w_timeout_hit) w_next = S_REL;
      end
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge gemmini_clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_rr           <= '0;
      r_cnt          <= '0;
      r_len          <= '0;
      r_dram_addr    <= '0;
      r_dpram_addr   <= '0;
      r_idle         <= '0;
      r_err_opcode   <= 1'b0;
      r_err_zero_len <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_err_opcode   <= 1'b0;
      r_err_zero_len <= 1'b0;
      r_err_timeout  <= w_timeout_hit;
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
      if (r_state == S_REL)             r_rr    <= rr_idx(r_grant, 1);
      if (!w_in_pkt || w_accept)        r_idle  <= '0;
      else if (w_idle_tick)             r_idle  <= r_idle + 32'd1;
      if (w_accept) begin
        if (r_state == S_HDR) begin
          r_dram_addr    <= w_ch_data[AW-1:0];
          r_dpram_addr   <= w_ch_data[55:40];
          r_len          <= w_hdr_len;
          r_cnt          <= '0;
          r_err_zero_len <= (w_hdr_len == 16'd0);
          r_err_opcode   <= (w_hdr_len != 16'd0) && (w_hdr_op != WR_OPCODE);
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign wcc_dram_addr  = r_dram_addr;
  assign wcc_dpram_addr = r_dpram_addr;
  assign wcc_length     = r_len;
  assign grant_id       = r_grant;
  assign busy           = (r_state != S_IDLE);
  assign err_opcode     = r_err_opcode;
  assign err_zero_len   = r_err_zero_len;
  assign err_timeout    = r_err_timeout;

endmodule

// File: tb/tb_tsn_dgcl_wr_arb.sv
// Directed bench for tsn_dgcl_wr_arb: inputs change and outputs are sampled on the falling edge.
module tb_tsn_dgcl_wr_arb;

  localparam int NUM_CH  = 4;
  localparam int DW      = 128;
  localparam int AW      = 40;
  localparam int TIMEOUT = 16;

  logic                 gemmini_clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    dma_req, dma_resp, dma_write_valid, dma_write_ready;
  logic [NUM_CH*DW-1:0] dma_write_data;
  logic [AW-1:0]        wcc_dram_addr;
  logic [15:0]          wcc_dpram_addr, wcc_length;
  logic [DW-1:0]        wcc_write_data;
  logic                 wcc_valid, wcc_ready;
  logic [1:0]           grant_id;
  logic                 busy, err_opcode, err_zero_len, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 gemmini_clk = ~gemmini_clk;

  tsn_dgcl_wr_arb #(
    .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .WR_OPCODE(8'h01), .TIMEOUT(TIMEOUT)
  ) dut (
    .gemmini_clk(gemmini_clk), .reset(reset),
    .dma_req(dma_req), .dma_resp(dma_resp),
    .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
    .dma_write_ready(dma_write_ready),
    .wcc_dram_addr(wcc_dram_addr), .wcc_dpram_addr(wcc_dpram_addr), .wcc_length(wcc_length),
    .wcc_write_data(wcc_write_data), .wcc_valid(wcc_valid), .wcc_ready(wcc_ready),
    .grant_id(grant_id), .busy(busy),
    .err_opcode(err_opcode), .err_zero_len(err_zero_len), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [AW-1:0] a, input logic [15:0] dp,
                                        input logic [15:0] len, input logic [7:0] op);
    logic [DW-1:0] h;
    h = '0;
    h[AW-1:0] = a;
    h[55:40]  = dp;
    h[71:56]  = len;
    h[79:72]  = op;
    return h;
  endfunction

  function automatic logic [DW-1:0] beat(input int ch, input int i);
    logic [DW-1:0] b;
    b = '0;
    b[127:96] = 32'hDA7A_5EED;
    b[15:8]   = 8'(ch);
    b[7:0]    = 8'(i);
    return b;
  endfunction

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    dma_write_data[ch*DW +: DW] = v;
  endtask

  // Waits (bounded) for any grant, then checks it went to the expected channel.
  task automatic wait_grant(input int ch);
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge gemmini_clk); #1;
      if (dma_resp != '0) got = 1'b1;
    end
    check("grant_resp", dma_resp, 128'd1 << ch);
    check("grant_id", grant_id, ch);
  endtask

  task automatic do_pkt(input int ch, input int len);
    wait_grant(ch);
    check("pkt_hdr_ready", dma_write_ready, 128'd1 << ch);
    dma_write_valid = 4'(1 << ch);
    set_data(ch, hdr(40'(ch * 256), 16'(ch + 16), 16'(len), 8'h01));
    for (int i = 0; i < len; i++) begin
      @(negedge gemmini_clk);
      set_data(ch, beat(ch, i));
      #1;
      check("pkt_wcc_valid", wcc_valid, 1);
      check("pkt_wcc_data", wcc_write_data, beat(ch, i));
    end
    @(negedge gemmini_clk);
    dma_write_valid = '0;
    #1;
    check("pkt_release", dma_resp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  edges;
    bit  got, seen_fwd, seen_to, seen_change;

    reset = 1'b1;
    dma_req = '0;
    dma_write_valid = '0;
    dma_write_data = '0;
    wcc_ready = 1'b0;
    repeat (3) @(negedge gemmini_clk);
    #1;
    check("rst_resp", dma_resp, 0);
    check("rst_ready", dma_write_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_wcc", {wcc_valid, wcc_length, wcc_dram_addr}, 0);
    check("rst_err", {err_opcode, err_zero_len, err_timeout}, 0);
    @(negedge gemmini_clk);
    reset = 1'b0;

    // Basic packet on ch0, L=3, grant one cycle after request
    @(negedge gemmini_clk);
    dma_req = 4'b0001;
    wcc_ready = 1'b1;
    #1;
    check("t1_resp_before", dma_resp, 0);
    @(negedge gemmini_clk); #1;
    check("t1_resp_rise", dma_resp, 4'b0001);
    check("t1_ready_hdr", dma_write_ready, 4'b0001);
    check("t1_busy", busy, 1);
    dma_write_valid = 4'b0001;
    set_data(0, hdr(40'h12_3456_789A, 16'hBEEF, 16'd3, 8'h01));
    for (int i = 0; i < 3; i++) begin
      @(negedge gemmini_clk);
      dma_req = '0;
      set_data(0, beat(0, i));
      #1;
      check("t1_wcc_valid", wcc_valid, 1);
      check("t1_wcc_data", wcc_write_data, beat(0, i));
      check("t1_resp_held", dma_resp, 4'b0001);
      if (i == 0) begin
        check("t1_dram_addr", wcc_dram_addr, 40'h12_3456_789A);
        check("t1_dpram_addr", wcc_dpram_addr, 16'hBEEF);
        check("t1_length", wcc_length, 3);
      end
    end
    @(negedge gemmini_clk);
    dma_write_valid = '0;
    #1;
    check("t1_resp_fall", dma_resp, 0);
    check("t1_wcc_idle", wcc_valid, 0);
    check("t1_len_held", wcc_length, 3);
    check("t1_rel_busy", busy, 1);
    @(negedge gemmini_clk); #1;
    check("t1_idle", busy, 0);

    // ch1 and ch3 together; ch1 keeps requesting but ch3 still gets its turn
    dma_req = 4'b1010;
    do_pkt(1, 2);
    do_pkt(3, 2);
    dma_req = 4'b0001;

    // Bad opcode: two beats drained, nothing forwarded
    wait_grant(0);
    dma_write_valid = 4'b0001;
    set_data(0, hdr(40'h55, 16'h66, 16'd2, 8'h05));
    dma_req = '0;
    @(negedge gemmini_clk);
    set_data(0, beat(0, 7));
    #1;
    check("t3_err_opcode", err_opcode, 1);
    check("t3_no_fwd0", wcc_valid, 0);
    check("t3_drain_ready", dma_write_ready, 4'b0001);
    check("t3_len", wcc_length, 2);
    @(negedge gemmini_clk);
    set_data(0, beat(0, 8));
    #1;
    check("t3_err_pulse_end", err_opcode, 0);
    check("t3_no_fwd1", wcc_valid, 0);
    check("t3_resp_held", dma_resp, 4'b0001);
    @(negedge gemmini_clk);
    dma_write_valid = '0;
    #1;
    check("t3_released", dma_resp, 0);
    check("t3_rel_busy", busy, 1);
    dma_req = 4'b0100;

    // Zero-length header
    wait_grant(2);
    dma_write_valid = 4'b0100;
    set_data(2, hdr(40'h77, 16'h88, 16'd0, 8'h01));
    dma_req = '0;
    @(negedge gemmini_clk);
    dma_write_valid = '0;
    #1;
    check("t4_err_zero_len", err_zero_len, 1);
    check("t4_resp_off", dma_resp, 0);
    check("t4_ready_off", dma_write_ready, 0);
    @(negedge gemmini_clk); #1;
    check("t4_idle", {busy, err_zero_len}, 0);

    // Timeout after first payload beat of L=4, then ch1 takes over
    dma_req = 4'b0011;
    wait_grant(0);
    dma_req = 4'b0010;
    dma_write_valid = 4'b0001;
    set_data(0, hdr(40'h99, 16'hAA, 16'd4, 8'h01));
    @(negedge gemmini_clk);
    set_data(0, beat(0, 0));
    #1;
    check("t5_beat0", wcc_valid, 1);
    @(negedge gemmini_clk);
    dma_write_valid = '0;
    edges = 0;
    got = 1'b0;
    seen_fwd = 1'b0;
    while (!got && edges < 40) begin
      @(posedge gemmini_clk);
      edges++;
      @(negedge gemmini_clk); #1;
      if (wcc_valid) seen_fwd = 1'b1;
      if (err_timeout) got = 1'b1;
    end
    check("t5_timeout_edges", edges, 16);
    check("t5_no_fwd", seen_fwd, 0);
    check("t5_resp_fall", dma_resp, 0);
    wait_grant(1);

    // Backpressure with valid held is not idle time; then reset mid-packet
    dma_req = '0;
    dma_write_valid = 4'b0010;
    set_data(1, hdr(40'hAB, 16'hCD, 16'd2, 8'h01));
    wcc_ready = 1'b0;
    @(negedge gemmini_clk);
    set_data(1, beat(1, 0));
    #1;
    check("t6_valid", wcc_valid, 1);
    check("t6_ready_low", dma_write_ready, 0);
    seen_to = 1'b0;
    seen_change = 1'b0;
    repeat (50) begin
      @(negedge gemmini_clk); #1;
      if (err_timeout) seen_to = 1'b1;
      if (dma_resp != 4'b0010 || wcc_write_data != beat(1, 0) || !wcc_valid) seen_change = 1'b1;
    end
    check("t6_no_timeout", seen_to, 0);
    check("t6_data_held", seen_change, 0);
    reset = 1'b1;
    #1;
    check("t6_rst_resp", {dma_resp, dma_write_ready}, 0);
    check("t6_rst_wcc", {wcc_valid, wcc_write_data}, 0);
    check("t6_rst_hdr", {wcc_length, wcc_dram_addr, wcc_dpram_addr}, 0);
    check("t6_rst_misc", {busy, grant_id, err_opcode, err_zero_len, err_timeout}, 0);
    @(negedge gemmini_clk);
    reset = 1'b0;
    dma_write_valid = '0;
    @(negedge gemmini_clk); #1;
    check("t6_post_rst_idle", {busy, dma_resp}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
